// File: rtl/clm_aes_job_arbiter.sv
// clm_aes_job_arbiter
//
// Round-robin arbiter and sequencer sharing one CLM AES core among NREQ requesters.
// A job (plaintext, key, p_det) is accepted from one requester while idle and latched.
// The core is then launched with a one-cycle start pulse, and its inputs are held
// stable from that grant until the next one. The ciphertext is captured on the
// core's done pulse and returned to the requester that owns the job.
//
// Optional build macro: CLM_ARB_WATCHDOG_EN
//   Defined:   a WAIT-state cycle counter aborts a job that does not finish within
//              TIMEOUT cycles. The abort pulses core_rst and returns an error
//              response (resp_err=1, ciphertext 0).
//   Undefined: WAIT waits indefinitely; core_rst and resp_err are tied low.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   req_valid        per-requester job valid
//   req_ready        per-requester job accept (one-hot or zero, combinational in IDLE)
//   req_plaintext    plaintext of requester k at bits [128k+:128]
//   req_key          key of requester k at bits [128k+:128]
//   req_p_det        p_det of requester k at bits [PDW*k+:PDW]
//   resp_valid       one-hot result valid towards the job owner
//   resp_ready       per-requester result accept (only the owner's bit is honoured)
//   resp_ciphertext  shared result bus
//   resp_err         result was aborted by the watchdog
//   busy             high whenever the sequencer is not idle
//   core_drdy_i      core start pulse
//   core_plaintext   held job plaintext
//   core_key         held job key
//   core_p_det       held job p_det
//   core_drdy_o      core done pulse; core_ciphertext is valid in the same cycle
//   core_ciphertext  core result
//   core_rst         core abort reset (watchdog builds only)
module clm_aes_job_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned PDW     = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [128*NREQ-1:0]   req_plaintext,
  input  logic [128*NREQ-1:0]   req_key,
  input  logic [PDW*NREQ-1:0]   req_p_det,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [127:0]          resp_ciphertext,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  core_drdy_i,
  output logic [127:0]          core_plaintext,
  output logic [127:0]          core_key,
  output logic [PDW-1:0]        core_p_det,
  input  logic                  core_drdy_o,
  input  logic [127:0]          core_ciphertext,
  output logic                  core_rst
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StWait  = 3'd2,
    StResp  = 3'd3,
    StAbort = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [127:0]      pt_q, pt_d;
  logic [127:0]      key_q, key_d;
  logic [PDW-1:0]    pdet_q, pdet_d;
  logic [127:0]      res_q, res_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   last_q, last_d;

  logic              grant_found;
  logic [IdxW-1:0]   grant_idx;
  logic [NREQ-1:0]   grant_oh;
  logic [127:0]      pt_sel;
  logic [127:0]      key_sel;
  logic [PDW-1:0]    pdet_sel;
  logic              owner_ack;

  // Round-robin pick: the lowest valid index above `last` wins; failing that, the
  // lowest valid index at or below `last` (wrap-around). Returns {found, index}.
  function automatic logic [IdxW:0] rr_pick(input logic [NREQ-1:0] valid,
                                            input logic [IdxW-1:0] last);
    logic            hi_found;
    logic            lo_found;
    logic [IdxW-1:0] hi_idx;
    logic [IdxW-1:0] lo_idx;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    // Descending scan so the final assignment in each half is its lowest index.
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (|(valid & (NREQ'(1'b1) << i))) begin
        if (i > int'(last)) begin
          hi_found = 1'b1;
          hi_idx   = IdxW'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = IdxW'(i);
        end
      end
    end
    return hi_found ? {1'b1, hi_idx} : {lo_found, lo_idx};
  endfunction

  assign {grant_found, grant_idx} = rr_pick(req_valid, last_q);
  assign grant_oh  = NREQ'(1'b1) << grant_idx;

  assign pt_sel    = 128'(req_plaintext >> (32'd128 * 32'(grant_idx)));
  assign key_sel   = 128'(req_key >> (32'd128 * 32'(grant_idx)));
  assign pdet_sel  = PDW'(req_p_det >> (PDW * 32'(grant_idx)));

  assign owner_ack = |(resp_ready & (NREQ'(1'b1) << owner_q));

`ifdef CLM_ARB_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`else
  // TIMEOUT only matters to the watchdog build.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d     = state_q;
    pt_d        = pt_q;
    key_d       = key_q;
    pdet_d      = pdet_q;
    res_d       = res_q;
    owner_d     = owner_q;
    last_d      = last_q;
    req_ready   = '0;
    resp_valid  = '0;
    core_drdy_i = 1'b0;
`ifdef CLM_ARB_WATCHDOG_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
    core_rst    = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        // Gated with rst so no accept is signalled while held in reset.
        if (grant_found && !rst) begin
          req_ready = grant_oh;
          pt_d      = pt_sel;
          key_d     = key_sel;
          pdet_d    = pdet_sel;
          owner_d   = grant_idx;
          state_d   = StStart;
        end
      end

      StStart: begin
        core_drdy_i = 1'b1;
        state_d     = StWait;
`ifdef CLM_ARB_WATCHDOG_EN
        cnt_d       = '0;
`endif
      end

      StWait: begin
        if (core_drdy_o) begin
          // Done in the same cycle as the timeout still completes the job.
          res_d   = core_ciphertext;
          state_d = StResp;
`ifdef CLM_ARB_WATCHDOG_EN
          err_d   = 1'b0;
`endif
        end
`ifdef CLM_ARB_WATCHDOG_EN
        else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CntW'(TIMEOUT)) begin
            state_d = StAbort;
          end
        end
`endif
      end

      StResp: begin
        resp_valid = NREQ'(1'b1) << owner_q;
        if (owner_ack) begin
          last_d  = owner_q;
          state_d = StIdle;
        end
      end

`ifdef CLM_ARB_WATCHDOG_EN
      StAbort: begin
        core_rst = 1'b1;
        res_d    = '0;
        err_d    = 1'b1;
        state_d  = StResp;
      end
`endif

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pt_q    <= '0;
      key_q   <= '0;
      pdet_q  <= '0;
      res_q   <= '0;
      owner_q <= '0;
      // First search after reset starts at requester 0.
      last_q  <= IdxW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      pt_q    <= pt_d;
      key_q   <= key_d;
      pdet_q  <= pdet_d;
      res_q   <= res_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

`ifdef CLM_ARB_WATCHDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
  assign core_rst = 1'b0;
`endif

  assign busy            = (state_q != StIdle);
  assign resp_ciphertext = res_q;
  assign core_plaintext  = pt_q;
  assign core_key        = key_q;
  assign core_p_det      = pdet_q;

endmodule

// File: doc/clm_aes_job_arbiter.md
Name: clm_aes_job_arbiter

Overview:
Round-robin arbiter and sequencer that shares one CLM AES core (16 parallel S-boxes plus key expansion) among NREQ requesters. It accepts jobs (plaintext, key, p_det) over per-requester valid/ready handshakes and launches the core with a one-cycle start pulse. It holds the core inputs stable for the whole job, captures the ciphertext on the core's done pulse, and returns it to the owning requester. It sits between the system request bus and the core's basic inouts interface plus its p_det input.

Parameters:
NREQ, 4, number of requesters (>=1)
PDW, 8, width of one p_det selector
TIMEOUT, 1024, watchdog limit in cycles (used only with CLM_ARB_WATCHDOG_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester job valid
req_ready  out  NREQ  per-requester job accept (one-hot or zero)
req_plaintext  in  128*NREQ  plaintext of requester k at bits [128k+:128]
req_key  in  128*NREQ  key of requester k at bits [128k+:128]
req_p_det  in  PDW*NREQ  p_det of requester k at bits [PDW*k+:PDW]
resp_valid  out  NREQ  one-hot result valid to the owner
resp_ready  in  NREQ  per-requester result accept
resp_ciphertext  out  128  shared result bus
resp_err  out  1  result aborted by watchdog
busy  out  1  high in any state other than IDLE
core_drdy_i  out  1  core start pulse
core_plaintext  out  128  held job plaintext
core_key  out  128  held job key
core_p_det  out  PDW  held job p_det
core_drdy_o  in  1  core done pulse; ciphertext is valid in this cycle
core_ciphertext  in  128  core result
core_rst  out  1  core abort reset (watchdog only)

Behaviour:
- Reset (rst is asynchronous, active-high; clock is clk): state=IDLE; all outputs 0; job, result and owner registers 0; last_grant=NREQ-1, so the first search starts at requester 0.
- FSM states: IDLE, START, WAIT, RESP, ABORT (ABORT only with the macro).
- IDLE, any req_valid set:
  - grant = first set index searching (last_grant+1) mod NREQ upward with wrap.
  - req_ready[grant]=1, combinational in that cycle; the handshake completes in this cycle.
  - Latch plaintext/key/p_det of grant into the job registers; owner=grant; go to START.
  - With no req_valid set, stay in IDLE and keep req_ready=0.
- START: core_drdy_i=1 for exactly one cycle; go to WAIT.
- WAIT: on core_drdy_o, capture core_ciphertext into the result register, set resp_err=0, go to RESP. Otherwise stay.
- RESP:
  - resp_valid[owner]=1; resp_ciphertext = result register.
  - On resp_ready[owner]: last_grant=owner, go to IDLE.
  - resp_ready on non-owner bits is ignored.
- core_plaintext, core_key and core_p_det are driven from the job registers at all times. They change only on an IDLE grant, because the core samples p_det and data in different internal stages.
- core_drdy_o outside WAIT is ignored.
- req_ready is 0 outside IDLE. A requester may deassert req_valid before it is granted without effect.
- Minimum spacing between core done and the next start is 2 cycles (RESP then IDLE then START), which guarantees the core has returned to its idle state.
- Fairness: with all requesters valid continuously, grants go 0,1,2,3,0,...
- Reset mid-job aborts the job silently; no response is produced.
- NREQ=1: grant is always 0.

Optional Feature:
CLM_ARB_WATCHDOG_EN
- With the macro:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If the counter reaches TIMEOUT without core_drdy_o, go to ABORT.
  - ABORT: core_rst=1 for one cycle, result register=0, resp_err=1, then go to RESP.
  - core_drdy_o in the same cycle the counter hits TIMEOUT wins; the job completes normally.
- Without the macro: no counter is built, WAIT waits indefinitely, and core_rst and resp_err are tied to 0.

Test Plan:
- Single job, requester 0, FIPS-197 key 000102..0f, plaintext 00112233..eeff, valid p_det table entry 0 -> one core_drdy_i pulse; resp_valid=0001; resp_ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a; busy returns to 0 the cycle after resp_ready.
- All four req_valid held high, resp_ready tied 1 -> grant order 0,1,2,3,0; each req_ready is one-hot and asserted only in IDLE.
- resp_ready held low 20 cycles -> resp_valid and resp_ciphertext stable; no new req_ready; no core_drdy_i.
- Change req_plaintext of the owning requester during WAIT -> core_plaintext unchanged; ciphertext matches the originally latched job.
- rst asserted during WAIT -> all outputs 0 immediately; next grant goes to requester 0.
- With CLM_ARB_WATCHDOG_EN, TIMEOUT=16, core stub never asserts done -> core_rst pulses at WAIT cycle 16; resp_err=1; resp_ciphertext=0.
